// File: rtl/nios2_oci_dct_pkg.sv
// Shared types and helpers for the OCI DCT trace capture block.
//   dct_state_e  : capture sequencer states
//   entry_w()    : width of one stored FIFO entry {count, payload}
//   dct_entry_t  : layout of one entry at the default widths
package nios2_oci_dct_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } dct_state_e;

  localparam int DEF_BUF_W = 30;
  localparam int DEF_CNT_W = 4;

  function automatic int entry_w(input int buf_w, input int cnt_w);
    return buf_w + cnt_w;
  endfunction

  // Count sits in the upper bits so a packed entry reads as {count, payload}.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] count;
    logic [DEF_BUF_W-1:0] payload;
  } dct_entry_t;

endpackage

// File: rtl/nios2_oci_dct_capture_fifo.sv
// Synchronous single-clock FIFO with a registered head entry.
//   clk, reset  : clock, synchronous active-high reset
//   push        : write wr_data (caller guarantees room, or a same-cycle pop)
//   pop         : consume the head entry (caller gates with head_valid)
//   flush       : discard all contents; takes priority over push/pop
//   wr_data     : entry to write
//   head_data   : registered head entry, zero when head_valid=0
//   head_valid  : head_data holds a stored entry
//   level       : entries currently stored
//   full, empty : level==DEPTH, level==0
module nios2_oci_dct_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             head_vld_q, head_vld_d;
  logic [LW-1:0]    remain;

  always_comb begin
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    count_d    = count_q + LW'(push) - LW'(pop);
    // The head is reloaded only from entries that were already stored before
    // this edge, so a push into an empty FIFO shows up one cycle later.
    remain     = count_q - LW'(pop);
    head_vld_d = (remain != '0);
    head_d     = head_vld_d ? mem_q[rd_ptr_d] : '0;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      head_vld_d = 1'b0;
      head_d     = '0;
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
    end
  end

  assign head_data  = head_q;
  assign head_valid = head_vld_q;
  assign level      = count_q;
  assign full       = (count_q == LW'(DEPTH));
  assign empty      = (count_q == '0);

endmodule

// File: rtl/nios2_oci_dct_capture.sv
// OCI DCT trace capture: qualifies trace beats, buffers them in a FIFO and
// streams them to a sink over valid/ready, sequenced by the test end signals.
//   clk, reset                 : clock, synchronous active-high reset
//   capture_en                 : arm capture (level)
//   dct_valid/dct_buffer/dct_count : incoming trace beat
//   test_ending                : graceful wind-down (drain then finish)
//   test_has_ended             : hard end, flushes the FIFO
//   out_valid/out_data/out_ready : stream of {dct_count, dct_buffer}
//   fifo_level                 : entries stored
//   overflow_cnt               : saturating count of dropped beats
//   beat_cnt                   : wrapping count of accepted beats
//   done                       : one-cycle pulse on entering DONE
//   aborted                    : sticky, DONE reached with data discarded
module nios2_oci_dct_capture
  import nios2_oci_dct_pkg::*;
#(
  parameter int BUF_W  = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int OVF_W  = 8,
  parameter int BEAT_W = 16,
  localparam int ENTRY_W = entry_w(BUF_W, CNT_W),
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               capture_en,
  input  logic               dct_valid,
  input  logic [BUF_W-1:0]   dct_buffer,
  input  logic [CNT_W-1:0]   dct_count,
  input  logic               test_ending,
  input  logic               test_has_ended,
  output logic               out_valid,
  output logic [ENTRY_W-1:0] out_data,
  input  logic               out_ready,
  output logic [LW-1:0]      fifo_level,
  output logic [OVF_W-1:0]   overflow_cnt,
  output logic [BEAT_W-1:0]  beat_cnt,
  output logic               done,
  output logic               aborted
);

  dct_state_e        state_q, state_d;
  logic [OVF_W-1:0]  ovf_q, ovf_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  logic beat_ok, pop, push_req, push_ok, drop, abort, clear;
  logic fifo_full, fifo_empty, head_valid;

  // A beat with no valid slots carries nothing and is ignored entirely.
  assign beat_ok  = dct_valid && (dct_count != '0);
  assign pop      = head_valid && out_ready;
  assign abort    = test_has_ended && (state_q == ST_CAPTURE || state_q == ST_DRAIN);
  assign push_req = beat_ok && (state_q == ST_CAPTURE) && !test_has_ended;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok  = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  nios2_oci_dct_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_ok),
    .pop        (pop),
    .flush      (abort),
    .wr_data    ({dct_count, dct_buffer}),
    .head_data  (out_data),
    .head_valid (head_valid),
    .level      (fifo_level),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    aborted_d = aborted_q;
    clear     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (capture_en) begin
          state_d = ST_CAPTURE;
          clear   = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (test_has_ended) begin
          state_d   = ST_DONE;
          aborted_d = !fifo_empty || beat_ok;
        end else if (test_ending) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (test_has_ended) begin
          state_d   = ST_DONE;
          aborted_d = !fifo_empty || beat_ok;
        end else if (fifo_empty && !head_valid) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!capture_en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear) begin
      aborted_d = 1'b0;
    end
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);

    beat_d = beat_q + BEAT_W'(push_ok);
    ovf_d  = ovf_q;
    if (drop && (ovf_q != '1)) begin
      ovf_d = ovf_q + 1'b1;
    end
    if (clear) begin
      beat_d = '0;
      ovf_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ovf_q     <= '0;
      beat_q    <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      beat_q    <= beat_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign out_valid    = head_valid;
  assign overflow_cnt = ovf_q;
  assign beat_cnt     = beat_q;
  assign done         = done_q;
  assign aborted      = aborted_q;

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Directed bench for nios2_oci_dct_capture. Two instances share stimulus:
// dut_a uses OVF_W=8, dut_b uses OVF_W=2 to exercise counter saturation.
module tb_nios2_oci_dct_capture;
  import nios2_oci_dct_pkg::*;

  localparam int BUF_W  = 30;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 16;
  localparam int BEAT_W = 16;
  localparam int EW     = BUF_W + CNT_W;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset, capture_en, dct_valid, test_ending, test_has_ended, out_ready;
  logic [BUF_W-1:0] dct_buffer;
  logic [CNT_W-1:0] dct_count;

  logic              out_valid_a, done_a, aborted_a;
  logic [EW-1:0]     out_data_a;
  logic [LW-1:0]     fifo_level_a;
  logic [7:0]        ovf_a;
  logic [BEAT_W-1:0] beat_a;

  logic              out_valid_b, done_b, aborted_b;
  logic [EW-1:0]     out_data_b;
  logic [LW-1:0]     fifo_level_b;
  logic [1:0]        ovf_b;
  logic [BEAT_W-1:0] beat_b;

  int n_tests = 0;
  int n_fail  = 0;
  int pops;

  always #5 clk = ~clk;

  nios2_oci_dct_capture #(
    .BUF_W(BUF_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .OVF_W(8), .BEAT_W(BEAT_W)
  ) dut_a (
    .clk(clk), .reset(reset), .capture_en(capture_en), .dct_valid(dct_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .out_valid(out_valid_a), .out_data(out_data_a),
    .out_ready(out_ready), .fifo_level(fifo_level_a), .overflow_cnt(ovf_a),
    .beat_cnt(beat_a), .done(done_a), .aborted(aborted_a)
  );

  nios2_oci_dct_capture #(
    .BUF_W(BUF_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .OVF_W(2), .BEAT_W(BEAT_W)
  ) dut_b (
    .clk(clk), .reset(reset), .capture_en(capture_en), .dct_valid(dct_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .out_valid(out_valid_b), .out_data(out_data_b),
    .out_ready(out_ready), .fifo_level(fifo_level_b), .overflow_cnt(ovf_b),
    .beat_cnt(beat_b), .done(done_b), .aborted(aborted_b)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EW-1:0] ent(input int c, input int p);
    dct_entry_t e;
    e.count   = CNT_W'(c);
    e.payload = BUF_W'(p);
    return e;
  endfunction

  task automatic drive(input int c, input int p);
    dct_valid  = 1'b1;
    dct_count  = CNT_W'(c);
    dct_buffer = BUF_W'(p);
  endtask

  task automatic nobeat();
    dct_valid  = 1'b0;
    dct_count  = '0;
    dct_buffer = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk_eq({tag, "_valid"},   out_valid_a,  0);
    chk_eq({tag, "_data"},    out_data_a,   0);
    chk_eq({tag, "_level"},   fifo_level_a, 0);
    chk_eq({tag, "_ovf"},     ovf_a,        0);
    chk_eq({tag, "_beat"},    beat_a,       0);
    chk_eq({tag, "_done"},    done_a,       0);
    chk_eq({tag, "_aborted"}, aborted_a,    0);
    chk_eq({tag, "_ovf_b"},   ovf_b,        0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; capture_en = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0;
    out_ready = 1'b0;
    nobeat();
    tick(); tick();
    chk_reset("rst");

    // Basic stream: 5 beats, count 3, payload 1..5, sink always ready.
    reset = 1'b0; capture_en = 1'b1; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive(3, i + 1); else nobeat();
      tick();
      if (i >= 1 && i <= 5) begin
        chk_eq("basic_valid", out_valid_a, 1);
        chk_eq("basic_data", out_data_a, ent(3, i));
      end
    end
    chk_eq("basic_empty_valid", out_valid_a, 0);
    chk_eq("basic_beat", beat_a, 5);
    chk_eq("basic_ovf", ovf_a, 0);
    chk_eq("basic_level", fifo_level_a, 0);

    // Fill past full with the sink stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(5, 100 + i);
      tick();
    end
    chk_eq("full_level", fifo_level_a, 16);
    chk_eq("full_ovf", ovf_a, 4);
    chk_eq("full_ovf_sat", ovf_b, 3);
    chk_eq("full_beat", beat_a, 21);
    chk_eq("full_head_stable", out_data_a, ent(5, 100));

    // Full with push and pop every cycle: level holds, nothing dropped.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(5, 120 + i);
      tick();
      chk_eq("fullpp_level", fifo_level_a, 16);
    end
    chk_eq("fullpp_ovf", ovf_a, 4);
    chk_eq("fullpp_head", out_data_a, ent(5, 105));
    chk_eq("fullpp_beat", beat_a, 26);

    // Abort with data queued; hard end overrides wind-down.
    nobeat(); out_ready = 1'b0;
    test_has_ended = 1'b1; test_ending = 1'b1;
    tick();
    chk_eq("abort_level", fifo_level_a, 0);
    chk_eq("abort_valid", out_valid_a, 0);
    chk_eq("abort_aborted", aborted_a, 1);
    chk_eq("abort_done", done_a, 1);
    test_has_ended = 1'b0; test_ending = 1'b0;
    tick();
    chk_eq("abort_done_pulse", done_a, 0);
    chk_eq("abort_sticky", aborted_a, 1);
    capture_en = 1'b0;
    tick();
    chk_eq("idle_beat_held", beat_a, 26);
    capture_en = 1'b1;
    tick();
    chk_eq("rearm_beat", beat_a, 0);
    chk_eq("rearm_ovf", ovf_a, 0);
    chk_eq("rearm_aborted", aborted_a, 0);

    // Graceful end: 6 queued, a 7th arrives with test_ending.
    for (int i = 0; i < 6; i++) begin
      drive(1, 200 + i);
      tick();
    end
    nobeat();
    tick();
    chk_eq("drain_pre_level", fifo_level_a, 6);
    pops = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        test_ending = 1'b1; out_ready = 1'b1; drive(1, 206);
      end else begin
        nobeat();
      end
      if (out_valid_a) begin
        chk_eq("drain_data", out_data_a, ent(1, 200 + pops));
        pops++;
      end
      tick();
      chk_eq("drain_done", done_a, (i == 7) ? 1 : 0);
    end
    chk_eq("drain_pops", pops, 7);
    chk_eq("drain_aborted", aborted_a, 0);
    chk_eq("drain_beat", beat_a, 7);
    test_ending = 1'b0;

    // Filtering and saturation.
    capture_en = 1'b0; tick();
    capture_en = 1'b1; tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dct_valid = 1'b1; dct_count = '0; dct_buffer = BUF_W'(32'h3ff);
      tick();
    end
    dct_valid = 1'b0; dct_count = 4'd7;
    tick();
    chk_eq("filt_level", fifo_level_a, 0);
    chk_eq("filt_beat", beat_a, 0);
    chk_eq("filt_valid", out_valid_a, 0);
    for (int i = 0; i < 26; i++) begin
      drive(2, 300 + i);
      tick();
    end
    nobeat();
    chk_eq("sat_level", fifo_level_a, 16);
    chk_eq("sat_beat", beat_a, 16);
    chk_eq("sat_ovf_b", ovf_b, 3);
    chk_eq("sat_ovf_a", ovf_a, 10);

    // Reset in the middle of DRAIN with 7 entries.
    reset = 1'b1; tick();
    reset = 1'b0; tick();
    for (int i = 0; i < 7; i++) begin
      drive(1, 400 + i);
      tick();
    end
    nobeat();
    test_ending = 1'b1;
    tick();
    chk_eq("mid_level", fifo_level_a, 7);
    reset = 1'b1;
    tick();
    chk_reset("midrst");
    reset = 1'b0; capture_en = 1'b0; test_ending = 1'b0;
    drive(1, 500);
    tick();
    chk_eq("idle_nopush", fifo_level_a, 0);
    nobeat(); capture_en = 1'b1;
    tick();
    chk_eq("recap_beat", beat_a, 0);
    drive(1, 501);
    tick();
    chk_eq("recap_level", fifo_level_a, 1);
    chk_eq("recap_beat1", beat_a, 1);
    nobeat();
    tick();
    chk_eq("recap_valid", out_valid_a, 1);
    chk_eq("recap_data", out_data_a, ent(1, 501));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
